// File: rtl/rocket_trace_ctrl_if.sv
// Core trace port seen by the capture controller: retire stream plus the
// trace buffer's current write pointer.
interface rocket_trace_ctrl_if #(
    parameter int ROCKET_MEM_ADDR_SIZE = 32
);
    logic                            trace_valid;
    logic [39:0]                     trace_iaddr;
    logic                            trace_exception;
    logic                            trace_interrupt;
    logic [ROCKET_MEM_ADDR_SIZE-1:0] trace_ptr;

    modport master (
        output trace_valid,
        output trace_iaddr,
        output trace_exception,
        output trace_interrupt,
        output trace_ptr
    );

    modport slave (
        input trace_valid,
        input trace_iaddr,
        input trace_exception,
        input trace_interrupt,
        input trace_ptr
    );
endinterface

// File: rtl/rocket_trace_ctrl.sv
// Trace capture sequencer: arm, wait for trigger, record N post-trigger
// retirements, then freeze the buffer. Define ROCKET_TRACE_EXC_TRIG_EN to
// also trigger on exceptions/interrupts.
module rocket_trace_ctrl #(
    parameter int ROCKET_MEM_ADDR_SIZE = 32,
    parameter int POST_CNT_WIDTH       = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            arm_i,
    input  logic                            stop_i,
    input  logic                            trig_addr_en_i,
    input  logic [39:0]                     trig_addr_i,
    input  logic [POST_CNT_WIDTH-1:0]       post_count_i,
    rocket_trace_ctrl_if.slave              trace_if,
    output logic                            trace_enabled_o,
    output logic [1:0]                      state_o,
    output logic                            triggered_o,
    output logic [ROCKET_MEM_ADDR_SIZE-1:0] trig_ptr_o,
    output logic [POST_CNT_WIDTH-1:0]       post_remaining_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                      state_reg, state_next;
    logic                            trace_enabled_reg, trace_enabled_next;
    logic                            triggered_reg, triggered_next;
    logic [ROCKET_MEM_ADDR_SIZE-1:0] trig_ptr_reg, trig_ptr_next;
    logic [POST_CNT_WIDTH-1:0]       post_remaining_reg, post_remaining_next;
    logic                            ptr_pending_reg, ptr_pending_next;
    logic                            addr_hit;
    logic                            exc_hit;
    logic                            trig;

    assign addr_hit = trig_addr_en_i && (trace_if.trace_iaddr == trig_addr_i);
`ifdef ROCKET_TRACE_EXC_TRIG_EN
    assign exc_hit = trace_if.trace_exception || trace_if.trace_interrupt;
`else
    assign exc_hit = 1'b0;
`endif
    assign trig = (state_reg == ST_ARMED) && trace_if.trace_valid && (addr_hit || exc_hit);

    always_comb begin
        state_next          = state_reg;
        triggered_next      = triggered_reg;
        post_remaining_next = post_remaining_reg;
        ptr_pending_next    = 1'b0;
        // The buffer registers its write data, so the trigger's slot is the
        // pointer presented one cycle after the trigger.
        trig_ptr_next       = ptr_pending_reg ? trace_if.trace_ptr : trig_ptr_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (arm_i && !stop_i) begin
                    state_next          = ST_ARMED;
                    triggered_next      = 1'b0;
                    post_remaining_next = post_count_i;
                end
            end
            ST_ARMED: begin
                if (stop_i) begin
                    state_next = ST_DONE;
                end else if (trig) begin
                    triggered_next   = 1'b1;
                    ptr_pending_next = 1'b1;
                    state_next       = (post_count_i == '0) ? ST_DONE : ST_POST;
                end
            end
            default: begin
                if (stop_i) begin
                    state_next = ST_DONE;
                end else if (trace_if.trace_valid) begin
                    if (post_remaining_reg <= POST_CNT_WIDTH'(1)) begin
                        post_remaining_next = '0;
                        state_next          = ST_DONE;
                    end else begin
                        post_remaining_next = post_remaining_reg - POST_CNT_WIDTH'(1);
                    end
                end
            end
        endcase

        trace_enabled_next = (state_next == ST_ARMED) || (state_next == ST_POST);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg          <= ST_IDLE;
            trace_enabled_reg  <= 1'b0;
            triggered_reg      <= 1'b0;
            trig_ptr_reg       <= '0;
            post_remaining_reg <= '0;
            ptr_pending_reg    <= 1'b0;
        end else begin
            state_reg          <= state_next;
            trace_enabled_reg  <= trace_enabled_next;
            triggered_reg      <= triggered_next;
            trig_ptr_reg       <= trig_ptr_next;
            post_remaining_reg <= post_remaining_next;
            ptr_pending_reg    <= ptr_pending_next;
        end
    end

    assign state_o          = state_reg;
    assign trace_enabled_o  = trace_enabled_reg;
    assign triggered_o      = triggered_reg;
    assign trig_ptr_o       = trig_ptr_reg;
    assign post_remaining_o = post_remaining_reg;
endmodule

// File: tb/tb_rocket_trace_ctrl.sv
// Testbench for rocket_trace_ctrl: directed scenarios then random traffic,
// all checked against a capture-window reference model.
module tb_rocket_trace_ctrl;
    localparam int AW = 32;
    localparam int PW = 16;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          trig_addr_en_i = 1'b0;
    logic [39:0]   trig_addr_i = '0;
    logic [PW-1:0] post_count_i = '0;
    logic          trace_enabled_o;
    logic [1:0]    state_o;
    logic          triggered_o;
    logic [AW-1:0] trig_ptr_o;
    logic [PW-1:0] post_remaining_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: capture window described as flags and a plain count
    bit          m_capturing, m_triggered, m_done, m_ptr_due;
    int unsigned m_remaining;
    logic [AW-1:0] m_trig_ptr;

    always #5 clk_i = ~clk_i;

    rocket_trace_ctrl_if #(.ROCKET_MEM_ADDR_SIZE(AW)) trace_if ();

    rocket_trace_ctrl #(.ROCKET_MEM_ADDR_SIZE(AW), .POST_CNT_WIDTH(PW)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .arm_i            (arm_i),
        .stop_i           (stop_i),
        .trig_addr_en_i   (trig_addr_en_i),
        .trig_addr_i      (trig_addr_i),
        .post_count_i     (post_count_i),
        .trace_if         (trace_if),
        .trace_enabled_o  (trace_enabled_o),
        .state_o          (state_o),
        .triggered_o      (triggered_o),
        .trig_ptr_o       (trig_ptr_o),
        .post_remaining_o (post_remaining_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_state();
        if (m_capturing) return m_triggered ? 2'd2 : 2'd1;
        return m_done ? 2'd3 : 2'd0;
    endfunction

    task automatic model_reset();
        m_capturing = 0; m_triggered = 0; m_done = 0; m_ptr_due = 0;
        m_remaining = 0; m_trig_ptr = '0;
    endtask

    task automatic model_step();
        bit hit;
        bit was_due;
        was_due = m_ptr_due;
        m_ptr_due = 0;
        if (was_due) m_trig_ptr = trace_if.trace_ptr;
        hit = trace_if.trace_valid && trig_addr_en_i && (trace_if.trace_iaddr == trig_addr_i);
`ifdef ROCKET_TRACE_EXC_TRIG_EN
        hit = hit || (trace_if.trace_valid && (trace_if.trace_exception || trace_if.trace_interrupt));
`endif
        if (stop_i && m_capturing) begin
            m_capturing = 0; m_done = 1;
        end else if (!m_capturing && arm_i && !stop_i) begin
            m_capturing = 1; m_done = 0; m_triggered = 0; m_remaining = post_count_i;
        end else if (m_capturing && !m_triggered && hit) begin
            m_triggered = 1; m_ptr_due = 1;
            if (post_count_i == 0) begin
                m_capturing = 0; m_done = 1;
            end
        end else if (m_capturing && m_triggered && trace_if.trace_valid) begin
            m_remaining = m_remaining - 1;
            if (m_remaining == 0) begin
                m_capturing = 0; m_done = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".state"}, 64'(state_o), 64'(model_state()));
        check_val({tag, ".enable"}, 64'(trace_enabled_o), 64'(m_capturing));
        check_val({tag, ".triggered"}, 64'(triggered_o), 64'(m_triggered));
        check_val({tag, ".trig_ptr"}, 64'(trig_ptr_o), 64'(m_trig_ptr));
        check_val({tag, ".remaining"}, 64'(post_remaining_o), 64'(m_remaining));
    endtask

    // One clock: model advances at the edge, outputs compared on the falling edge
    task automatic tick(input string tag);
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all(tag);
    endtask

    task automatic clear_inputs();
        arm_i = 0; stop_i = 0;
        trace_if.trace_valid = 0; trace_if.trace_exception = 0; trace_if.trace_interrupt = 0;
        trace_if.trace_iaddr = 40'h0; trace_if.trace_ptr = '0;
    endtask

    task automatic do_reset();
        reset_n_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1;
    endtask

    task automatic pulse(input bit arm, input bit stop, input string tag);
        arm_i = arm; stop_i = stop;
        tick(tag);
        arm_i = 0; stop_i = 0;
    endtask

    initial begin
        logic [63:0] rnd;
        clear_inputs();
        do_reset();
        check_val("reset.state", 64'(state_o), 64'd0);
        check_val("reset.enable", 64'(trace_enabled_o), 64'd0);
        check_val("reset.triggered", 64'(triggered_o), 64'd0);
        check_val("reset.trig_ptr", 64'(trig_ptr_o), 64'd0);
        check_val("reset.remaining", 64'(post_remaining_o), 64'd0);
        $display("[TB] reset state checked");

        // Address trigger with a 4-instruction post window
        post_count_i = 4; trig_addr_i = 40'h00_8000_0100; trig_addr_en_i = 1;
        pulse(1, 0, "d1.arm");
        check_val("d1.armed", 64'(state_o), 64'd1);
        check_val("d1.armed_en", 64'(trace_enabled_o), 64'd1);
        trace_if.trace_valid = 1; trace_if.trace_iaddr = 40'h00_8000_0100; trace_if.trace_ptr = 32'h24;
        tick("d1.trig");
        check_val("d1.post", 64'(state_o), 64'd2);
        check_val("d1.trig_flag", 64'(triggered_o), 64'd1);
        trace_if.trace_valid = 0; trace_if.trace_ptr = 32'h25;
        tick("d1.ptr");
        check_val("d1.trig_ptr", 64'(trig_ptr_o), 64'h25);
        check_val("d1.rem_hold", 64'(post_remaining_o), 64'd4);
        trace_if.trace_iaddr = 40'h00_8000_0104;
        for (int i = 1; i <= 4; i++) begin
            trace_if.trace_valid = 1; trace_if.trace_ptr = AW'(32'h25 + i);
            tick("d1.post_valid");
            if (i < 4) check_val("d1.still_on", 64'(trace_enabled_o), 64'd1);
        end
        trace_if.trace_valid = 0;
        check_val("d1.done", 64'(state_o), 64'd3);
        check_val("d1.done_en", 64'(trace_enabled_o), 64'd0);
        $display("[TB] address trigger capture, trig_ptr=0x%0h", trig_ptr_o);

        // Zero-length post window goes straight to DONE
        post_count_i = 0;
        pulse(1, 0, "d2.arm");
        trace_if.trace_valid = 1; trace_if.trace_iaddr = 40'h00_8000_0100;
        tick("d2.trig");
        trace_if.trace_valid = 0;
        check_val("d2.done", 64'(state_o), 64'd3);
        check_val("d2.trig_flag", 64'(triggered_o), 64'd1);
        check_val("d2.remaining", 64'(post_remaining_o), 64'd0);
        $display("[TB] zero post count capture");

        // Priority of stop
        do_reset();
        pulse(1, 1, "d3.arm_stop");
        check_val("d3.idle", 64'(state_o), 64'd0);
        post_count_i = 2;
        pulse(1, 0, "d3.arm");
        trace_if.trace_valid = 1; trace_if.trace_iaddr = 40'h00_8000_0100;
        pulse(0, 1, "d3.stop_trig");
        trace_if.trace_valid = 0;
        check_val("d3.done", 64'(state_o), 64'd3);
        check_val("d3.no_trig", 64'(triggered_o), 64'd0);
        $display("[TB] stop priority checked");

        // Asynchronous reset in the middle of a post window
        post_count_i = 3;
        pulse(1, 0, "d4.arm");
        trace_if.trace_valid = 1;
        tick("d4.trig");
        trace_if.trace_valid = 0;
        check_val("d4.rem3", 64'(post_remaining_o), 64'd3);
        #2 reset_n_i = 0;
        #1;
        model_reset();
        check_val("d4.async_state", 64'(state_o), 64'd0);
        check_val("d4.async_en", 64'(trace_enabled_o), 64'd0);
        check_val("d4.async_rem", 64'(post_remaining_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1;
        pulse(1, 0, "d4.rearm");
        check_val("d4.armed", 64'(state_o), 64'd1);
        $display("[TB] async reset mid-capture checked");

        // Exception/interrupt trigger with the address trigger disabled
        trig_addr_en_i = 0;
        trace_if.trace_valid = 1; trace_if.trace_exception = 1; trace_if.trace_iaddr = 40'h12_3456_7890;
        tick("d5.exc");
        trace_if.trace_valid = 0; trace_if.trace_exception = 0;
`ifdef ROCKET_TRACE_EXC_TRIG_EN
        check_val("d5.exc_state", 64'(state_o), 64'd2);
`else
        check_val("d5.exc_state", 64'(state_o), 64'd1);
`endif
        $display("[TB] exception trigger checked");

        // Random traffic against the model
        do_reset();
        rnd = {$urandom, $urandom};
        trig_addr_i = rnd[39:0];
        for (int c = 0; c < 3000; c++) begin
            bit was_done;
            if (($urandom % 400) == 0) begin
                do_reset();
                compare_all("rnd.reset");
            end
            if (!m_capturing) post_count_i = PW'($urandom_range(0, 5));
            arm_i = ($urandom % 8) == 0;
            stop_i = ($urandom % 24) == 0;
            trig_addr_en_i = ($urandom % 4) != 0;
            trace_if.trace_valid = ($urandom % 2) == 0;
            trace_if.trace_exception = ($urandom % 12) == 0;
            trace_if.trace_interrupt = ($urandom % 16) == 0;
            trace_if.trace_ptr = $urandom;
            case ($urandom % 4)
                0: trace_if.trace_iaddr = trig_addr_i;
                1: trace_if.trace_iaddr = trig_addr_i ^ 40'h80_0000_0000;
                2: trace_if.trace_iaddr = trig_addr_i ^ 40'h00_0000_0001;
                default: begin
                    rnd = {$urandom, $urandom};
                    trace_if.trace_iaddr = rnd[39:0];
                end
            endcase
            was_done = m_done;
            tick("rnd");
            if (m_done && !was_done)
                $display("[TB] capture ended cycle %0d triggered=%0d trig_ptr=0x%0h", c, m_triggered, m_trig_ptr);
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rocket_trace_ctrl.md
# rocket_trace_ctrl

Capture controller that sequences the Rocket instruction trace buffer. It arms recording from a register-file command, watches the retired-instruction stream for a trigger condition, and records a programmable number of post-trigger instructions. It then freezes the buffer by dropping the trace enable, so software reads a window around the event. It sits between the register file and the trace buffer's `trace_enabled_i` input, alongside the core trace port.

## Interface
- `ROCKET_MEM_ADDR_SIZE`, 32, width of the buffer pointer input and the captured trigger pointer.
- `POST_CNT_WIDTH`, 16, width of the post-trigger instruction counter.

- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `arm_i`  in  1  single-cycle pulse that starts a capture.
- `stop_i`  in  1  single-cycle pulse that aborts or ends a capture.
- `trig_addr_en_i`  in  1  enables the instruction-address trigger.
- `trig_addr_i`  in  40  trigger instruction address.
- `post_count_i`  in  POST_CNT_WIDTH  number of retired instructions to record after the trigger.
- `trace_valid`  in  1  core trace: instruction retired.
- `trace_iaddr`  in  40  core trace: instruction address.
- `trace_exception`  in  1  core trace: exception.
- `trace_interrupt`  in  1  core trace: interrupt.
- `trace_ptr_i`  in  ROCKET_MEM_ADDR_SIZE  trace buffer write pointer.
- `trace_enabled_o`  out  1  enable to the trace buffer; registered.
- `state_o`  out  2  FSM state: IDLE=0, ARMED=1, POST=2, DONE=3.
- `triggered_o`  out  1  sticky flag: a trigger occurred in the current capture.
- `trig_ptr_o`  out  ROCKET_MEM_ADDR_SIZE  buffer slot of the trigger instruction.
- `post_remaining_o`  out  POST_CNT_WIDTH  post-trigger instructions still to be recorded.

## Operation
- **Reset values:** state IDLE, `trace_enabled_o`=0, `triggered_o`=0, `trig_ptr_o`=0, `post_remaining_o`=0.
- **Trigger event** (`trig`): `trace_valid && trig_addr_en_i && trace_iaddr==trig_addr_i`, evaluated only in ARMED. All 40 address bits are compared.
- **IDLE** or **DONE**:
  - `arm_i` -> ARMED.
  - On the same transition: `triggered_o` cleared, `post_remaining_o` loaded from `post_count_i`, `trace_enabled_o` set.
- **ARMED** (pre-trigger recording, buffer wraps freely):
  - `trig` -> POST, `triggered_o` set.
  - If `post_count_i`==0 at the trigger, go to DONE instead of POST.
- **POST:**
  - Each `trace_valid` decrements `post_remaining_o`.
  - A `trace_valid` while `post_remaining_o`==1 -> DONE, counter reaches 0.
  - Non-valid cycles leave the counter unchanged.
- **DONE:** `trace_enabled_o`=0; buffer contents and pointer are frozen until the next `arm_i`.
- **`stop_i`** in ARMED or POST -> DONE. `triggered_o` and `trig_ptr_o` keep their current values. `stop_i` in IDLE or DONE has no effect.
- **Priority:** `stop_i` wins over `arm_i` and over a trigger in the same cycle. A trigger blocked by `stop_i` is not captured.
- **`arm_i` in ARMED or POST** is ignored; no re-arm mid-capture.
- **Trigger pointer:** `trig_ptr_o` captures `trace_ptr_i` one cycle after the trigger cycle. That is the slot the buffer writes for the trigger instruction, because the buffer registers its write data by one cycle.
- **Counting basis:** `post_remaining_o` counts retired instructions, not buffer entries. Duplicate trace words the buffer suppresses still decrement the counter.

## Timing
- **Arm latency:** `arm_i` high at cycle t -> `state_o` and `trace_enabled_o` updated at t+1. The first instruction recorded is the one retiring at t+1.
- **Trigger:** trigger at t -> `state_o`=POST and `triggered_o`=1 at t+1; `trig_ptr_o` valid at t+2.
- **End of capture:** the last post-trigger `trace_valid` at t still sees `trace_enabled_o`=1 and is recorded. `trace_enabled_o`=0 from t+1.
- **`stop_i` at t:** `trace_enabled_o`=0 at t+1. Instructions retiring at t are still recorded.
- **Reset asserted mid-capture:** immediately returns to the reset values above; the buffer stops recording.

## Configuration
- **`ROCKET_TRACE_EXC_TRIG_EN` defined:** `trig` also fires on `trace_valid && (trace_exception || trace_interrupt)` in ARMED, independent of `trig_addr_en_i`.
- **Undefined:** `trace_exception` and `trace_interrupt` are unused; only the address trigger exists.

## Test plan
- Reset -> `state_o`=0, `trace_enabled_o`=0, `triggered_o`=0, `trig_ptr_o`=0.
- `post_count_i`=4, `trig_addr_i`=0x80000100, arm, retire 0x80000100 at cycle t with `trace_ptr_i`=0x25 at t+1 -> POST at t+1, `trig_ptr_o`=0x25 at t+2. DONE and `trace_enabled_o`=0 one cycle after the 4th subsequent valid.
- `post_count_i`=0, trigger -> DONE directly at t+1, `triggered_o`=1, `post_remaining_o`=0.
- `stop_i` and `arm_i` together in IDLE -> stays IDLE. `stop_i` and trigger together in ARMED -> DONE with `triggered_o`=0.
- Reset pulse in POST with `post_remaining_o`=3 -> IDLE, enable 0, counter 0. Then `arm_i` -> ARMED normally.
- With `ROCKET_TRACE_EXC_TRIG_EN`, `trig_addr_en_i`=0, valid plus exception in ARMED -> POST. Without the macro, the same stimulus stays in ARMED.
